// File: rtl/remote_cmd_sequencer.sv
// IR remote key sequencer: repeat filter, key FIFO, and a BCD entry FSM that
// commits the typed number to a valid/ready consumer.
module remote_cmd_sequencer #(
  parameter int          DIGITS     = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  KEY_OK     = 8'h12,
  parameter logic [7:0]  KEY_CLR    = 8'h10,
  parameter logic [15:0] HOLDOFF    = 16'd5000,
  parameter logic [23:0] TIMEOUT    = 24'd500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          key_code,
  input  logic                key_valid,
  output logic [4*DIGITS-1:0] cmd_value,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [4*DIGITS-1:0] entry,
  output logic [2:0]          digit_cnt,
  output logic                key_drop,
  output logic                key_err,
  output logic                timeout
);

  localparam int CW = 4 * DIGITS;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

  function automatic logic [15:0] hold_sat_inc(input logic [15:0] cnt);
    return (cnt < HOLDOFF) ? cnt + 16'd1 : HOLDOFF;
  endfunction

  state_t          state, state_nxt;
  logic [7:0]      last_key;
  logic [15:0]     hold_cnt;
  logic [23:0]     idle_cnt, idle_nxt;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, is_repeat, key_in, push, pop;
  logic [7:0]      pop_key;
  logic [CW-1:0]   entry_nxt, cmd_value_nxt;
  logic [2:0]      cnt_nxt;
  logic            cmd_valid_nxt, err_nxt, tmo_nxt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign is_repeat = (key_code == last_key) && (hold_cnt < HOLDOFF);
  assign key_in    = key_valid && !is_repeat;
  assign pop       = !empty && (state != COMMIT);
  // A full FIFO still accepts a key when the head leaves on the same edge.
  assign push      = key_in && (!full || pop);
  assign pop_key   = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= key_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_key <= 8'hFF;
      hold_cnt <= '0;
      key_drop <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (key_in) begin
        last_key <= key_code;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_sat_inc(hold_cnt);
      end
      key_drop <= key_in && full && !pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    entry_nxt     = entry;
    cnt_nxt       = digit_cnt;
    cmd_value_nxt = cmd_value;
    cmd_valid_nxt = cmd_valid;
    idle_nxt      = idle_cnt;
    err_nxt       = 1'b0;
    tmo_nxt       = 1'b0;
    case (state)
      COMMIT: begin
        if (cmd_valid && cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          entry_nxt     = '0;
          cnt_nxt       = '0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        if (pop) begin
          idle_nxt = '0;
          if (pop_key <= 8'h09) begin
            if (digit_cnt < 3'(DIGITS)) begin
              entry_nxt = {entry[CW-5:0], pop_key[3:0]};
              cnt_nxt   = digit_cnt + 3'd1;
              state_nxt = ENTRY;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (pop_key == KEY_CLR) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (pop_key == KEY_OK) begin
            if (digit_cnt != 3'd0) begin
              cmd_value_nxt = entry;
              cmd_valid_nxt = 1'b1;
              state_nxt     = COMMIT;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end else if (state == ENTRY) begin
          if (idle_cnt == TIMEOUT) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
            tmo_nxt   = 1'b1;
            idle_nxt  = '0;
          end else begin
            idle_nxt = idle_cnt + 24'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry     <= '0;
      digit_cnt <= '0;
      cmd_value <= '0;
      cmd_valid <= 1'b0;
      idle_cnt  <= '0;
      key_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      entry     <= entry_nxt;
      digit_cnt <= cnt_nxt;
      cmd_value <= cmd_value_nxt;
      cmd_valid <= cmd_valid_nxt;
      idle_cnt  <= idle_nxt;
      key_err   <= err_nxt;
      timeout   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// Directed bench for remote_cmd_sequencer with shortened holdoff/timeout.
module tb_remote_cmd_sequencer;

  localparam int HOLD = 20;
  localparam int TMO  = 100;
  localparam logic [7:0] OK  = 8'h12;
  localparam logic [7:0] CLR = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_code;
  logic        key_valid;
  logic [15:0] cmd_value;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        key_drop, key_err, timeout;

  int checks = 0;
  int errors = 0;

  remote_cmd_sequencer #(
    .DIGITS(4), .FIFO_DEPTH(4), .KEY_OK(OK), .KEY_CLR(CLR),
    .HOLDOFF(16'(HOLD)), .TIMEOUT(24'(TMO))
  ) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .cmd_value(cmd_value), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .entry(entry), .digit_cnt(digit_cnt), .key_drop(key_drop),
    .key_err(key_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse one key; returns at the negedge after the key has been popped.
  task automatic press(input logic [7:0] c);
    @(negedge clk); key_code = c; key_valid = 1'b1;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_val"},   32'(cmd_value), 32'h0);
    chk({tag, "_vld"},   32'(cmd_valid), 32'h0);
    chk({tag, "_entry"}, 32'(entry),     32'h0);
    chk({tag, "_cnt"},   32'(digit_cnt), 32'h0);
    chk({tag, "_pulse"}, {29'd0, key_drop, key_err, timeout}, 32'h0);
  endtask

  int drops;
  int n;

  initial begin
    rst = 1'b1; key_code = 8'h00; key_valid = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst_init");
    rst = 1'b0;

    // Async reset mid-entry
    press(8'h01); press(8'h02);
    chk("pre_rst_entry", 32'(entry), 32'h0012);
    chk("pre_rst_cnt", 32'(digit_cnt), 32'd2);
    @(negedge clk); #1 rst = 1'b1;
    #1 chk_all_zero("rst_mid");
    @(negedge clk); rst = 1'b0;

    // 1,2,3,OK with consumer ready
    cmd_ready = 1'b1;
    press(8'h01); press(8'h02); press(8'h03);
    chk("e123_entry", 32'(entry), 32'h0123);
    press(OK);
    chk("e123_vld", 32'(cmd_valid), 32'h1);
    chk("e123_val", 32'(cmd_value), 32'h0123);
    @(negedge clk);
    chk("e123_vld_drop", 32'(cmd_valid), 32'h0);
    chk("e123_val_hold", 32'(cmd_value), 32'h0123);
    chk("e123_cnt_clr", 32'(digit_cnt), 32'd0);

    // Five digits: the fifth is rejected
    press(8'h09); press(8'h08); press(8'h07); press(8'h06);
    chk("e9876_cnt", 32'(digit_cnt), 32'd4);
    chk("e9876_noerr", 32'(key_err), 32'h0);
    press(8'h05);
    chk("e9876_err", 32'(key_err), 32'h1);
    chk("e9876_entry", 32'(entry), 32'h9876);
    press(OK);
    chk("e9876_val", 32'(cmd_value), 32'h9876);
    chk("e9876_vld", 32'(cmd_valid), 32'h1);
    @(negedge clk);

    // Held key repeats within holdoff are swallowed
    press(8'h04); press(8'h04); press(8'h04);
    chk("rep_entry", 32'(entry), 32'h0004);
    chk("rep_cnt", 32'(digit_cnt), 32'd1);
    chk("rep_noerr", 32'(key_err), 32'h0);
    press(OK);
    chk("rep_val", 32'(cmd_value), 32'h0004);
    @(negedge clk);

    // Consumer stalled in COMMIT: FIFO fills, fifth key lost
    cmd_ready = 1'b0;
    press(8'h01); press(OK);
    chk("stall_vld", 32'(cmd_valid), 32'h1);
    chk("stall_val", 32'(cmd_value), 32'h0001);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drops += int'(key_drop);
      key_code = 8'(5 + i); key_valid = 1'b1;
    end
    @(negedge clk); drops += int'(key_drop); key_valid = 1'b0;
    @(negedge clk); drops += int'(key_drop);
    chk("stall_drops", 32'(drops), 32'd1);
    chk("stall_entry", 32'(entry), 32'h0001);
    chk("stall_vld_held", 32'(cmd_valid), 32'h1);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("hs_vld", 32'(cmd_valid), 32'h0);
    chk("hs_cnt", 32'(digit_cnt), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("drain_cnt", 32'(digit_cnt), 32'(k));
    end
    chk("drain_entry", 32'(entry), 32'h5678);
    press(CLR);
    chk("clr_entry", 32'(entry), 32'h0);
    chk("clr_cnt", 32'(digit_cnt), 32'd0);
    chk("clr_noerr", 32'(key_err), 32'h0);

    // Inactivity timeout
    press(8'h07);
    chk("tmo_entry0", 32'(entry), 32'h0007);
    n = 0;
    while (!timeout && n < 3 * TMO) begin
      @(negedge clk); n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO + 1));
    chk("tmo_entry", 32'(entry), 32'h0);
    chk("tmo_cnt", 32'(digit_cnt), 32'd0);
    @(negedge clk);
    chk("tmo_pulse_end", 32'(timeout), 32'h0);
    press(OK);
    chk("ok_empty_err", 32'(key_err), 32'h1);
    chk("ok_empty_novld", 32'(cmd_valid), 32'h0);
    press(OK);
    chk("ok_repeat_filtered", 32'(key_err), 32'h0);
    repeat (HOLD + 5) @(negedge clk);
    press(OK);
    chk("ok_after_holdoff", 32'(key_err), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
